// File: rtl/sc_spi_pkg.sv
// Shared types and constants for the SPI target engine: FSM states, SPI mode
// encodings ({CPOL,CPHA}) and bit-order selection.
package sc_spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam logic BORDER_MSB = 1'b0;
    localparam logic BORDER_LSB = 1'b1;

    // Mask covering bits [dwidth:0] of a right-aligned word.
    function automatic logic [31:0] word_mask(input logic [4:0] dwidth);
        return 32'hFFFF_FFFF >> (5'd31 - dwidth);
    endfunction

endpackage

// File: rtl/sc_spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detection
// on the synchronized value.
module sc_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            q_d   <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            q_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/sc_spi_target.sv
// SPI target engine, oversampled in the SYSCLK domain.
// Optional macro SC_SPI_TARGET_WORDCNT_EN adds the WORDCNT per-frame word counter.
module sc_spi_target
    import sc_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        SYSCLK,
    input  logic        SYSRSTB,
    input  logic        ENABLE,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [4:0]  DWIDTH,
    input  logic [31:0] TXDATA,
    input  logic        TXVALID,
    output logic        TXREADY,
    output logic        TXUNDERRUN,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic        SPIBUSY,
    input  logic        CSB,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
`ifdef SC_SPI_TARGET_WORDCNT_EN
    output logic        MISO_OE,
    output logic [15:0] WORDCNT
`else
    output logic        MISO_OE
`endif
);

    spi_state_t  state, state_nxt;
    logic        sclk_s, sclk_rise, sclk_fall;
    logic        csb_s, csb_rise, csb_fall;
    logic        mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic        unused_edges;

    logic        cpol_l, cpha_l, border_l;
    logic [4:0]  dwidth_l;
    logic [31:0] hold_data, tx_sr, rx_sr, rx_next, tx_shifted;
    logic        hold_full, tx_bit, tx_write;
    logic [4:0]  bit_cnt;
    logic        first_pending, word_done;
    logic        lead, trail, start, leave, sample_ev, drive_ev, load_word;

    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(SYSCLK), .rst_n(SYSRSTB), .d(SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(SYSCLK), .rst_n(SYSRSTB), .d(CSB), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
    );
    sc_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(SYSCLK), .rst_n(SYSRSTB), .d(MOSI), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    assign unused_edges = ^{sclk_s, csb_fall, mosi_rise_unused, mosi_fall_unused};

    assign lead  = cpol_l ? sclk_fall : sclk_rise;
    assign trail = cpol_l ? sclk_rise : sclk_fall;

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        leave     = 1'b0;
        sample_ev = 1'b0;
        drive_ev  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ENABLE && !csb_s) begin
                    start     = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (csb_rise) begin
                    leave     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    sample_ev = cpha_l ? trail : lead;
                    drive_ev  = cpha_l ? lead  : trail;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign SPIBUSY   = (state == ST_SHIFT);
    assign MISO_OE   = SPIBUSY;
    assign TXREADY   = ~hold_full;
    assign tx_write  = TXVALID & ~hold_full;
    assign load_word = start | (sample_ev & (bit_cnt == dwidth_l));

    always_comb begin
        rx_next    = '0;
        tx_bit     = 1'b0;
        tx_shifted = '0;
        if (border_l == BORDER_MSB) begin
            rx_next    = {rx_sr[30:0], mosi_s};
            tx_bit     = tx_sr[dwidth_l];
            tx_shifted = tx_sr << 1;
        end else begin
            rx_next           = rx_sr >> 1;
            rx_next[dwidth_l] = mosi_s;
            tx_bit            = tx_sr[0];
            tx_shifted        = tx_sr >> 1;
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            cpol_l        <= 1'b0;
            cpha_l        <= 1'b0;
            border_l      <= BORDER_MSB;
            dwidth_l      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            first_pending <= 1'b0;
            word_done     <= 1'b0;
            MISO          <= 1'b0;
            TXUNDERRUN    <= 1'b0;
            RXDATA        <= '0;
            RXVALID       <= 1'b0;
        end else begin
            TXUNDERRUN    <= 1'b0;
            RXVALID       <= word_done;
            word_done     <= 1'b0;
            first_pending <= 1'b0;
            if (word_done)
                RXDATA <= rx_sr & word_mask(dwidth_l);
            if (start) begin
                cpol_l        <= CPOL;
                cpha_l        <= CPHA;
                border_l      <= BORDER;
                dwidth_l      <= DWIDTH;
                bit_cnt       <= '0;
                first_pending <= ~CPHA;
            end
            if (sample_ev) begin
                rx_sr <= rx_next;
                if (bit_cnt == dwidth_l) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            // With CPHA=0 no SCLK edge precedes bit 0, so it is presented the cycle after the load.
            if (drive_ev || (first_pending && state == ST_SHIFT)) begin
                MISO  <= tx_bit;
                tx_sr <= tx_shifted;
            end
            if (leave)
                MISO <= 1'b0;
            if (load_word) begin
                tx_sr      <= hold_full ? hold_data : '0;
                TXUNDERRUN <= ~hold_full;
            end
            if (tx_write) begin
                hold_data <= TXDATA;
                hold_full <= 1'b1;
            end else if (load_word) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef SC_SPI_TARGET_WORDCNT_EN
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB)
            WORDCNT <= '0;
        else if (start)
            WORDCNT <= '0;
        else if (word_done && WORDCNT != 16'hFFFF)
            WORDCNT <= WORDCNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sc_spi_target.sv
// Directed bench for sc_spi_target: a bit-banged SPI master plus a word-level
// expectation model (queues of expected RX words and MISO words).
module tb_sc_spi_target;
    import sc_spi_pkg::*;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int H = SYNC_STAGES + 3;

    logic        SYSCLK, SYSRSTB, ENABLE, CPOL, CPHA, BORDER;
    logic [4:0]  DWIDTH;
    logic [31:0] TXDATA, RXDATA;
    logic        TXVALID, TXREADY, TXUNDERRUN, RXVALID, SPIBUSY;
    logic        CSB, SCLK, MOSI, MISO, MISO_OE;
`ifdef SC_SPI_TARGET_WORDCNT_EN
    logic [15:0] WORDCNT;
`endif

    sc_spi_target #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .SYSCLK(SYSCLK), .SYSRSTB(SYSRSTB), .ENABLE(ENABLE), .CPOL(CPOL), .CPHA(CPHA),
        .BORDER(BORDER), .DWIDTH(DWIDTH), .TXDATA(TXDATA), .TXVALID(TXVALID),
        .TXREADY(TXREADY), .TXUNDERRUN(TXUNDERRUN), .RXDATA(RXDATA), .RXVALID(RXVALID),
        .SPIBUSY(SPIBUSY), .CSB(CSB), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
`ifdef SC_SPI_TARGET_WORDCNT_EN
        .MISO_OE(MISO_OE), .WORDCNT(WORDCNT)
`else
        .MISO_OE(MISO_OE)
`endif
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_sample_cyc = 0;
    int ur_cnt = 0;
    int rxv_cnt = 0;
    int ur_base, rxv_base;
    int ur_snap [4];
    bit chk_busy = 1'b0;
    logic exp_busy = 1'b0;
    logic [31:0] exp_rx [$];
    logic [31:0] exp_miso [$];
    logic [31:0] mwords [4];

    always @(posedge SYSCLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // Single compare process: frame status every cycle, RX words on each RXVALID.
    always @(negedge SYSCLK) begin
        if (SYSRSTB) begin
            if (chk_busy) begin
                chk("spibusy", 32'(SPIBUSY), 32'(exp_busy));
                chk("miso_oe", 32'(MISO_OE), 32'(exp_busy));
            end
            if (TXUNDERRUN) ur_cnt++;
            if (RXVALID) begin
                rxv_cnt++;
                chk("rxvalid_latency", 32'(cyc - last_sample_cyc), 32'(SYNC_STAGES + 2));
                if (exp_rx.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rxvalid_unexpected: got RXVALID with RXDATA 0x%08h, expected no word", RXDATA);
                end else begin
                    chk("rxdata", RXDATA, exp_rx.pop_front());
                end
            end
        end
    end

    task automatic set_cfg(input logic [1:0] mode, input logic border, input logic [4:0] dw);
        @(negedge SYSCLK);
        CPOL = mode[1];
        CPHA = mode[0];
        BORDER = border;
        DWIDTH = dw;
        SCLK = mode[1];
        repeat (6) @(negedge SYSCLK);
    endtask

    task automatic tx_write(input logic [31:0] data);
        int t = 0;
        while (!TXREADY && t < 400) begin
            @(negedge SYSCLK);
            t++;
        end
        if (!TXREADY) begin
            n_chk++;
            n_fail++;
            $display("FAIL tx_write_timeout: got TXREADY=0 after %0d cycles, expected 1", t);
        end else begin
            TXDATA = data;
            TXVALID = 1'b1;
            @(negedge SYSCLK);
            TXVALID = 1'b0;
            chk("txready_after_write", 32'(TXREADY), 32'd0);
        end
    endtask

    // Master: sends mwords[0..nw-1], stops after abort_bits bits (negative = never).
    task automatic spi_frame(input int nw, input int abort_bits);
        int d;
        int sent;
        int idx;
        bit aborted;
        logic [31:0] got;
        d = int'(DWIDTH);
        sent = 0;
        aborted = 1'b0;
        chk_busy = 1'b0;
        @(negedge SYSCLK);
        CSB = 1'b0;
        repeat (8) @(negedge SYSCLK);
        exp_busy = ENABLE;
        chk_busy = 1'b1;
        for (int w = 0; w < nw && !aborted; w++) begin
            got = '0;
            ur_snap[w] = ur_cnt;
            for (int b = 0; b <= d; b++) begin
                if (sent == abort_bits) begin
                    aborted = 1'b1;
                    break;
                end
                idx = BORDER ? b : d - b;
                if (!CPHA) begin
                    MOSI = mwords[w][idx];
                    repeat (H) @(negedge SYSCLK);
                    SCLK = ~CPOL;
                    got[idx] = MISO;
                    last_sample_cyc = cyc;
                    repeat (H) @(negedge SYSCLK);
                    SCLK = CPOL;
                end else begin
                    SCLK = ~CPOL;
                    MOSI = mwords[w][idx];
                    repeat (H) @(negedge SYSCLK);
                    SCLK = CPOL;
                    got[idx] = MISO;
                    last_sample_cyc = cyc;
                    repeat (H) @(negedge SYSCLK);
                end
                sent++;
            end
            if (!aborted && exp_busy && exp_miso.size() > 0)
                chk("miso_word", got, exp_miso.pop_front());
        end
        repeat (H) @(negedge SYSCLK);
        chk_busy = 1'b0;
        CSB = 1'b1;
        repeat (6) @(negedge SYSCLK);
        exp_busy = 1'b0;
        chk_busy = 1'b1;
        repeat (4) @(negedge SYSCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500 us, expected end of test");
        $fatal(1);
    end

    initial begin
        SYSRSTB = 1'b0; ENABLE = 1'b1; CPOL = 1'b0; CPHA = 1'b0; BORDER = 1'b0;
        DWIDTH = 5'd7; TXDATA = '0; TXVALID = 1'b0; CSB = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (3) @(negedge SYSCLK);
        chk("rst_txready", 32'(TXREADY), 32'd1);
        chk("rst_txunderrun", 32'(TXUNDERRUN), 32'd0);
        chk("rst_rxdata", RXDATA, 32'd0);
        chk("rst_rxvalid", 32'(RXVALID), 32'd0);
        chk("rst_spibusy", 32'(SPIBUSY), 32'd0);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_miso_oe", 32'(MISO_OE), 32'd0);
        SYSRSTB = 1'b1;
        repeat (4) @(negedge SYSCLK);
        chk_busy = 1'b1;

        // Mode 0, 8-bit MSB first: A5 out, 3C in.
        set_cfg(MODE0, BORDER_MSB, 5'd7);
        ur_base = ur_cnt; rxv_base = rxv_cnt;
        tx_write(32'h0000_00A5);
        exp_miso.push_back(32'h0000_00A5);
        exp_rx.push_back(32'h0000_003C);
        mwords[0] = 32'h0000_003C;
        spi_frame(1, -1);
        chk("t1_rxdata", RXDATA, 32'h0000_003C);
        chk("t1_rxvalid_count", 32'(rxv_cnt - rxv_base), 32'd1);
        chk("t1_underruns", 32'(ur_cnt - ur_base), 32'd1);
        chk("t1_txready", 32'(TXREADY), 32'd1);

        // Mode 3, 16-bit LSB first.
        set_cfg(MODE3, BORDER_LSB, 5'd15);
        ur_base = ur_cnt;
        tx_write(32'h0000_1234);
        exp_miso.push_back(32'h0000_1234);
        exp_rx.push_back(32'h0000_BEEF);
        mwords[0] = 32'h0000_BEEF;
        spi_frame(1, -1);
        chk("t2_rxdata", RXDATA, 32'h0000_BEEF);
        chk("t2_underruns", 32'(ur_cnt - ur_base), 32'd1);

        // Three 32-bit words in one frame, only two TX words supplied.
        set_cfg(MODE0, BORDER_MSB, 5'd31);
        ur_base = ur_cnt; rxv_base = rxv_cnt;
        tx_write(32'h1111_1111);
        exp_miso.push_back(32'h1111_1111);
        exp_miso.push_back(32'h2222_2222);
        exp_miso.push_back(32'h0000_0000);
        mwords[0] = 32'hDEAD_BEEF; mwords[1] = 32'h0123_4567; mwords[2] = 32'h8000_0001;
        exp_rx.push_back(32'hDEAD_BEEF);
        exp_rx.push_back(32'h0123_4567);
        exp_rx.push_back(32'h8000_0001);
        fork
            spi_frame(3, -1);
            tx_write(32'h2222_2222);
        join
        chk("t3_underrun_before_word3", 32'(ur_snap[2] - ur_base), 32'd1);
        // The extra pulse is the empty load that follows completion of word 3.
        chk("t3_underruns_total", 32'(ur_cnt - ur_base), 32'd2);
        chk("t3_rxvalid_count", 32'(rxv_cnt - rxv_base), 32'd3);
`ifdef SC_SPI_TARGET_WORDCNT_EN
        chk("t3_wordcnt", 32'(WORDCNT), 32'd3);
`endif

        // Abort after 5 of 8 bits; a word written mid-frame must survive to the next frame.
        set_cfg(MODE0, BORDER_MSB, 5'd7);
        ur_base = ur_cnt; rxv_base = rxv_cnt;
        mwords[0] = 32'h0000_00FF;
        fork
            spi_frame(1, 5);
            begin
                repeat (20) @(negedge SYSCLK);
                tx_write(32'h0000_0096);
            end
        join
        chk("t4_abort_rxvalid", 32'(rxv_cnt - rxv_base), 32'd0);
        chk("t4_abort_spibusy", 32'(SPIBUSY), 32'd0);
        chk("t4_abort_miso_oe", 32'(MISO_OE), 32'd0);
        chk("t4_hold_untouched", 32'(TXREADY), 32'd0);
        chk("t4_abort_underruns", 32'(ur_cnt - ur_base), 32'd1);
        exp_miso.push_back(32'h0000_0096);
        exp_rx.push_back(32'h0000_0081);
        mwords[0] = 32'h0000_0081;
        spi_frame(1, -1);
        chk("t4_rxdata", RXDATA, 32'h0000_0081);
`ifdef SC_SPI_TARGET_WORDCNT_EN
        chk("t4_wordcnt", 32'(WORDCNT), 32'd1);
`endif

        // ENABLE=0: bus ignored entirely.
        ur_base = ur_cnt; rxv_base = rxv_cnt;
        tx_write(32'h0000_0077);
        ENABLE = 1'b0;
        mwords[0] = 32'h0000_00C3;
        spi_frame(1, -1);
        chk("t5_rxvalid", 32'(rxv_cnt - rxv_base), 32'd0);
        chk("t5_txready", 32'(TXREADY), 32'd0);
        chk("t5_underruns", 32'(ur_cnt - ur_base), 32'd0);
        chk("t5_rxdata_kept", RXDATA, 32'h0000_0081);
        ENABLE = 1'b1;

        // Reset in the middle of a mode-1 frame, then a clean frame.
        set_cfg(MODE1, BORDER_MSB, 5'd7);
        chk_busy = 1'b0;
        CSB = 1'b0;
        repeat (8) @(negedge SYSCLK);
        chk("t6_busy_before_reset", 32'(SPIBUSY), 32'd1);
        for (int b = 0; b < 3; b++) begin
            SCLK = 1'b1; MOSI = 1'b1;
            repeat (H) @(negedge SYSCLK);
            SCLK = 1'b0;
            repeat (H) @(negedge SYSCLK);
        end
        SYSRSTB = 1'b0;
        #1;
        chk("t6_rst_txready", 32'(TXREADY), 32'd1);
        chk("t6_rst_txunderrun", 32'(TXUNDERRUN), 32'd0);
        chk("t6_rst_rxdata", RXDATA, 32'd0);
        chk("t6_rst_rxvalid", 32'(RXVALID), 32'd0);
        chk("t6_rst_spibusy", 32'(SPIBUSY), 32'd0);
        chk("t6_rst_miso", 32'(MISO), 32'd0);
        chk("t6_rst_miso_oe", 32'(MISO_OE), 32'd0);
        CSB = 1'b1;
        SCLK = CPOL;
        repeat (3) @(negedge SYSCLK);
        SYSRSTB = 1'b1;
        repeat (6) @(negedge SYSCLK);
        exp_busy = 1'b0;
        chk_busy = 1'b1;
        ur_base = ur_cnt;
        tx_write(32'h0000_003D);
        exp_miso.push_back(32'h0000_003D);
        exp_rx.push_back(32'h0000_006B);
        mwords[0] = 32'h0000_006B;
        spi_frame(1, -1);
        chk("t6_rxdata", RXDATA, 32'h0000_006B);
        chk("t6_underruns", 32'(ur_cnt - ur_base), 32'd1);

        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        chk("miso_queue_drained", 32'(exp_miso.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_spi_target.md
Name: sc_spi_target

Overview:
SPI target (slave) protocol engine. It is the receive-side counterpart of the SPI initiator engine, used to let the FPGA be addressed by an external SPI master.
- SCLK, CSB and MOSI are oversampled in the single SYSCLK domain.
- Received words are delivered with a valid pulse.
- Transmit words are supplied through a valid/ready holding register and shifted out on MISO.
- Mode, bit order and word width follow the same CPOL/CPHA/BORDER/DWIDTH conventions as the initiator.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the SCLK/CSB/MOSI synchronizers (legal 2..4)

Ports:
SYSCLK  in  1  system clock; the only clock
SYSRSTB  in  1  asynchronous active-low reset
ENABLE  in  1  1 = respond to CSB; 0 = ignore bus, MISO_OE=0
CPOL  in  1  SCLK idle level
CPHA  in  1  0 = sample on leading edge; 1 = sample on trailing edge
BORDER  in  1  0 = MSB first; 1 = LSB first
DWIDTH  in  5  bits per word minus 1 (word length 1..32)
TXDATA  in  32  transmit word, right-aligned in [DWIDTH:0]
TXVALID  in  1  TXDATA valid
TXREADY  out  1  holding register empty
TXUNDERRUN  out  1  1-cycle pulse: word started with empty holding register
RXDATA  out  32  last received word, right-aligned, upper bits 0
RXVALID  out  1  1-cycle pulse: RXDATA updated
SPIBUSY  out  1  frame active (CSB asserted and accepted)
CSB  in  1  chip select from master, active-low
SCLK  in  1  serial clock from master
MOSI  in  1  master-out data
MISO  out  1  target-out data
MISO_OE  out  1  MISO output enable

Behaviour:
Reset values: TXREADY=1, TXUNDERRUN=0, RXDATA=0, RXVALID=0, SPIBUSY=0, MISO=0, MISO_OE=0; holding register empty; FSM in IDLE.

Synchronization:
- SCLK, CSB and MOSI each pass through SYNC_STAGES flops; edges are detected on the synchronized value.
- Leading edge = SCLK leaving the CPOL level; trailing edge = SCLK returning to it.

Frame and timing rules:
- CPOL/CPHA/BORDER/DWIDTH are latched at frame start and held constant for the frame.
- Usable SCLK: each SCLK phase must be >= SYNC_STAGES+2 SYSCLK cycles.
- CSB fall to first SCLK edge must be >= SYNC_STAGES+2 SYSCLK cycles.

FSM states:
- IDLE: wait for synchronized CSB=0 with ENABLE=1. Then latch config, load the word, set SPIBUSY=1 and MISO_OE=1, go to SHIFT.
- SHIFT, sample edge (leading if CPHA=0, trailing if CPHA=1):
  - shift the MOSI sample into the RX shift register;
  - increment the bit counter.
- SHIFT, drive edge (the opposite edge):
  - present the next TX bit on MISO;
  - for CPHA=1 the first bit is driven on the first leading edge;
  - for CPHA=0 the first bit is on MISO one cycle after load.
- Word complete (counter == DWIDTH at a sample edge):
  - RXDATA <= assembled word; RXVALID pulses on the next cycle;
  - counter clears; next TX word loaded; stay in SHIFT.
- CSB rise (synchronized) in any state: go to IDLE. SPIBUSY=0 and MISO_OE=0 in the same cycle.

Word load rules:
- If the holding register is full, the shift register takes its contents, the holding register empties and TXREADY rises.
- If it is empty, the shift register loads 0 and TXUNDERRUN pulses.
- Holding handshake: a write occurs when TXVALID&TXREADY; TXREADY falls the next cycle.
- If a load and a write occur in the same cycle, the load empties the register and the new write fills it; TXREADY stays 0.

Bit order:
- BORDER=0: TX starts from bit DWIDTH; RX shifts left into bit 0.
- BORDER=1: TX starts from bit 0; RX fills from bit DWIDTH downward.

Boundary conditions:
- CSB rise mid-word: partial RX discarded, no RXVALID, loaded TX word lost, holding register untouched.
- ENABLE falling mid-frame: the frame completes; it takes effect at the next frame.
- SCLK edges while CSB high: ignored.

Latency:
- RXVALID asserts SYNC_STAGES+2 SYSCLK cycles after the final sampling pin edge.
- A MISO update follows its drive pin edge by SYNC_STAGES+1 cycles.

Optional Feature:
Macro: SC_SPI_TARGET_WORDCNT_EN
- Defined: adds output WORDCNT [15:0], the count of completed words in the current frame.
  - Clears at frame start; increments with each RXVALID; saturates at 0xFFFF; holds its value after CSB rise.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Decomposition:
- Package sc_spi_pkg: FSM state encoding (IDLE, SHIFT), mode constants (MODE0..MODE3 as {CPOL,CPHA}), and the BORDER encoding constants.
- Sub-module sc_spi_sync: SYNC_STAGES synchronizer plus rise/fall edge detect. Instantiated for SCLK and CSB; MOSI uses the synchronizer output only.

Test Plan:
- Mode 0, DWIDTH=7, BORDER=0: TX 0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RXDATA=0x0000003C, one RXVALID.
- Mode 3, DWIDTH=15, BORDER=1: TX 0x1234, master sends 0xBEEF -> MISO LSB first yields 0x1234 at master; RXDATA=0x0000BEEF.
- CSB held low for 3 words, DWIDTH=31, TX words 0x11111111/0x22222222 then none -> two correct words, third MISO=0, one TXUNDERRUN pulse, three RXVALID.
- CSB deasserted after 5 of 8 bits -> no RXVALID, SPIBUSY=0, MISO_OE=0; next frame receives 0x81 correctly.
- ENABLE=0 during a full 8-bit frame -> MISO_OE=0 throughout, no RXVALID, TXREADY unchanged.
- Reset asserted mid-frame -> all outputs at reset values immediately; after release, the next frame works with correct RXDATA.
